// File: rtl/if_fetch_ctl_if.sv
// ---------------------------------------------------------------------------
// if_fetch_ctl_if
// Bundles every non-clock signal of the IF fetch controller.
//   Control in  : cpu_start, cpu_stop, start_adr, stall, jmp_condition, jmp_adr
//   RAM bus     : ram_radr (to RAM), ram_rdata (from RAM, one cycle later)
//   IF/ID out   : inst_id, pc_id, valid_id, cpu_running
// modport slave  : the fetch controller itself.
// modport master : the surrounding pipeline / RAM / debug controller.
//
// There is no back-pressure handshake on IF/ID: valid_id marks the entry
// as a live instruction, and stall is the only way downstream holds it.
// An entry is consumed on every edge where valid_id=1 and stall=0.
// ---------------------------------------------------------------------------
interface if_fetch_ctl_if;
   logic        cpu_start;
   logic        cpu_stop;
   logic [31:0] start_adr;
   logic        stall;
   logic        jmp_condition;
   logic [31:0] jmp_adr;
   logic [9:0]  ram_radr;
   logic [31:0] ram_rdata;
   logic [31:0] inst_id;
   logic [31:0] pc_id;
   logic        valid_id;
   logic        cpu_running;

   modport slave (
      input  cpu_start, cpu_stop, start_adr, stall, jmp_condition, jmp_adr,
      input  ram_rdata,
      output ram_radr, inst_id, pc_id, valid_id, cpu_running
   );

   modport master (
      output cpu_start, cpu_stop, start_adr, stall, jmp_condition, jmp_adr,
      output ram_rdata,
      input  ram_radr, inst_id, pc_id, valid_id, cpu_running
   );
endinterface

// File: rtl/if_fetch_ctl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctl
// IF-stage fetch control for the RV32I pipeline. Generates the PC, drives
// the read address of a 1024x32 instruction RAM with a registered-address
// (one-cycle) read, and captures the returned word with its PC into the
// IF/ID register.
// Ports:
//   clk      : single clock, all state on posedge
//   rst      : synchronous active-high reset
//   fetch_io : if_fetch_ctl_if.slave (control, RAM bus, IF/ID outputs)
// The FSM state is visible as fetch_io.cpu_running (1 = RUN).
// ---------------------------------------------------------------------------
module if_fetch_ctl #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic           clk,
   input  logic           rst,
   if_fetch_ctl_if.slave  fetch_io
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;       // address whose data is on ram_rdata now
   logic        f_valid_q, f_valid_d;
   logic [31:0] inst_id_q, inst_id_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic        valid_id_q, valid_id_d;
   logic [31:0] nxt_pc;

   // Word-alignment bits of the address inputs are intentionally dropped.
   logic unused_adr_bits;
   assign unused_adr_bits = ^{fetch_io.start_adr[1:0], fetch_io.jmp_adr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_f_q     <= 32'h0;
         f_valid_q  <= 1'b0;
         inst_id_q  <= NOP_INST;
         pc_id_q    <= 32'h0;
         valid_id_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_f_q     <= pc_f_d;
         f_valid_q  <= f_valid_d;
         inst_id_q  <= inst_id_d;
         pc_id_q    <= pc_id_d;
         valid_id_q <= valid_id_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_f_d     = pc_f_q;
      f_valid_d  = f_valid_q;
      inst_id_d  = inst_id_q;
      pc_id_d    = pc_id_q;
      valid_id_d = valid_id_q;
      nxt_pc     = pc_f_q + 32'd4;

      case (state_q)
         IDLE: begin
            // Keep presenting the boot address so the first word is already
            // on ram_rdata in the cycle after start is taken.
            nxt_pc     = {fetch_io.start_adr[31:2], 2'b00};
            pc_f_d     = nxt_pc;
            f_valid_d  = 1'b0;
            valid_id_d = 1'b0;
            if (fetch_io.cpu_start && !fetch_io.cpu_stop) begin
               state_d   = RUN;
               f_valid_d = 1'b1;
            end
         end
         RUN: begin
            if (fetch_io.jmp_condition)
               nxt_pc = {fetch_io.jmp_adr[31:2], 2'b00};
            else if (fetch_io.stall)
               nxt_pc = pc_f_q;   // re-read same word so RAM output is held
            pc_f_d    = nxt_pc;
            f_valid_d = 1'b1;

            if (fetch_io.cpu_stop) begin
               state_d    = IDLE;
               valid_id_d = 1'b0;
               inst_id_d  = NOP_INST;
               f_valid_d  = 1'b0;
            end else if (fetch_io.jmp_condition) begin
               // Word on ram_rdata is wrong-path; open a one-entry bubble.
               valid_id_d = 1'b0;
            end else if (!fetch_io.stall) begin
               inst_id_d  = fetch_io.ram_rdata;
               pc_id_d    = pc_f_q;
               valid_id_d = f_valid_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM index wraps every 4 KB; PC registers keep the full 32-bit value.
   assign fetch_io.ram_radr    = nxt_pc[11:2];
   assign fetch_io.inst_id     = inst_id_q;
   assign fetch_io.pc_id       = pc_id_q;
   assign fetch_io.valid_id    = valid_id_q;
   assign fetch_io.cpu_running = (state_q == RUN);

endmodule

// File: doc/if_fetch_ctl.md
# if_fetch_ctl

Fetch control for the IF stage of the RV32I pipeline. Generates the PC, drives the read address of the 1024×32 instruction RAM (one-cycle registered-address read), and captures the returned word together with its PC into the IF/ID pipeline register. Handles start/stop from the debug controller, stalls from ID hazard logic, and redirects from EX branch/jump resolution.

## Interface
Parameters:
- NOP_INST, 32'h0000_0013, word loaded into inst_id on reset and stop (addi x0,x0,0)

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- cpu_start  in  1  one-cycle pulse: begin fetching at start_adr
- cpu_stop  in  1  one-cycle pulse: stop fetching, return to IDLE
- start_adr  in  32  boot PC; bits [1:0] ignored
- stall  in  1  hold IF and IF/ID contents
- jmp_condition  in  1  redirect taken this cycle (from EX)
- jmp_adr  in  32  redirect target; bits [1:0] ignored
- ram_radr  out  10  instruction RAM word address (combinational)
- ram_rdata  in  32  instruction RAM read data, valid one cycle after address
- inst_id  out  32  IF/ID instruction
- pc_id  out  32  IF/ID PC
- valid_id  out  1  IF/ID entry holds a live instruction
- cpu_running  out  1  high in RUN state

## Operation
- Registers: state (IDLE/RUN), pc_f[31:0] (address whose data is on ram_rdata this cycle), f_valid, inst_id, pc_id, valid_id.
- Reset values: state=IDLE, pc_f=0, f_valid=0, inst_id=NOP_INST, pc_id=0, valid_id=0, cpu_running=0.
- IDLE:
  - ram_radr = start_adr[11:2]; pc_f <= {start_adr[31:2],2'b00}; f_valid <= 0; valid_id <= 0.
  - cpu_start & !cpu_stop -> RUN, f_valid <= 1. Stop wins over a simultaneous start.
  - stall, jmp_condition ignored.
- RUN, next-PC mux (priority high to low):
  1. jmp_condition: nxt_pc = {jmp_adr[31:2],2'b00}
  2. stall: nxt_pc = pc_f (re-present same address, RAM output held)
  3. else nxt_pc = pc_f + 4 (mod 2^32)
- RUN: ram_radr = nxt_pc[11:2]; pc_f <= nxt_pc; f_valid <= 1.
- IF/ID capture in RUN:
  - jmp_condition: valid_id <= 0 (fetched word is wrong-path); inst_id/pc_id don't-care, may hold. Jump overrides stall.
  - else stall: inst_id, pc_id, valid_id hold.
  - else inst_id <= ram_rdata, pc_id <= pc_f, valid_id <= f_valid.
- cpu_stop in RUN -> IDLE at next edge; valid_id <= 0, inst_id <= NOP_INST, f_valid <= 0; overrides jump and stall.
- cpu_start while in RUN: ignored.
- Address wrap: RAM index uses pc bits [11:2], so fetch wraps every 4 KB; pc_f/pc_id keep full 32-bit value.
- Instruction RAM writes by the loader occur only while IDLE; no read/write hazard handling here.

## Timing
- RAM latency 1: address presented in cycle t, ram_rdata valid in t+1, IF/ID updated at end of t+1.
- Start: pulse sampled at edge E0 -> cpu_running high after E0; valid_id=1, pc_id=start_adr after E1.
- Steady state: one instruction per cycle, pc_id increments by 4 per edge.
- Stall held N cycles: IF/ID and pc_f frozen N edges; first edge after stall drops captures the same instruction that was pending; no instruction lost or duplicated.
- Redirect at edge Ej: valid_id=0 after Ej; valid_id=1, pc_id=jmp_adr after Ej+1 (one bubble). The instruction already in ID at Ej is killed by downstream, not here.
- Reset mid-run: all registers take reset values at the next edge regardless of other inputs.

## Test plan
- Reset then cpu_start with start_adr=0x0000_0000, RAM[0..3]=0x11,0x22,0x33,0x44 -> after E1..E4 (inst_id,pc_id)=(0x11,0),(0x22,4),(0x33,8),(0x44,0xC), valid_id=1.
- Stall for 3 cycles while pc_id=0x8 -> inst_id=0x33, pc_id=0x8 held 3 edges; next edges yield pc_id 0xC, 0x10 with no gap or repeat.
- jmp_condition with jmp_adr=0x200 while stall=1 -> valid_id=0 one edge, then pc_id=0x200, inst_id=RAM[0x80], valid_id=1.
- Run from start_adr=0xFF8 -> pc_id 0xFF8, 0xFFC, 0x1000 with ram_radr 0x3FE, 0x3FF, 0x000 (wrap).
- cpu_stop mid-run -> next edge valid_id=0, inst_id=0x0000_0013, cpu_running=0; cpu_start+cpu_stop same cycle in IDLE -> stays IDLE.
- Assert rst for one cycle while running and stalled -> all outputs return to reset values; ram_radr follows start_adr[11:2].
